div_sequencer: RTL

- Multi-cycle controller that sequences the shared 32-bit add/sub arithmetic unit to execute the RV32M divide group: DIV, DIVU, REM and REMU.
- Uses a restoring algorithm, one quotient bit per cycle.
- Owns the arithmetic unit's operand and op inputs only while busy.
- Sits beside the ALU in the execute stage; the core stalls on o_busy and consumes the result through a valid/ack handshake.

---
 rtl/div_sequencer.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/div_sequencer.sv
// Restoring RV32M divider (DIV/DIVU/REM/REMU) that borrows the shared add/sub unit while busy.
// Optional single-entry result cache enabled by defining DIV_RESULT_CACHE_EN.
module div_sequencer #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_ready,
    output logic            o_busy,
    output logic            o_valid,
    input  logic            i_ack,
    output logic [XLEN-1:0] o_result,
    output logic [XLEN-1:0] o_arith_a,
    output logic [XLEN-1:0] o_arith_b,
    output logic [1:0]      o_arith_op,
    input  logic [XLEN-1:0] i_arith_result
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0]   LAST_CNT = CW'(ITERS - 1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [1:0]      OP_SUB   = 2'b01;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NEG_A = 3'd1,
        NEG_B = 3'd2,
        ITER  = 3'd3,
        FIX   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic            rem_q, rem_d;
    logic            sa_q, sa_d;
    logic            sb_q, sb_d;
    logic [XLEN-1:0] q_q, q_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] r_q, r_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] result_q, result_d;

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] sel;
    logic            ge;
    logic            neg;
    logic            signed_op;
    logic            cache_hit;

`ifdef DIV_RESULT_CACHE_EN
    logic            uns_q, uns_d;
    logic [XLEN-1:0] a_orig_q, a_orig_d;
    logic [XLEN-1:0] b_orig_q, b_orig_d;
    logic            c_valid_q, c_valid_d;
    logic            c_uns_q, c_uns_d;
    logic [XLEN-1:0] c_a_q, c_a_d;
    logic [XLEN-1:0] c_b_q, c_b_d;
    logic [XLEN-1:0] c_quo_q, c_quo_d;
    logic [XLEN-1:0] c_rem_q, c_rem_d;

    assign cache_hit = c_valid_q && (i_dividend == c_a_q) && (i_divisor == c_b_q)
                       && (i_op[0] == c_uns_q);
`else
    assign cache_hit = 1'b0;
`endif

    // R[31] acts as the carry-out of the 33-bit partial remainder
    assign shifted   = {r_q[XLEN-2:0], q_q[XLEN-1]};
    assign ge        = r_q[XLEN-1] | (shifted >= dvs_q);
    assign sel       = rem_q ? r_q : q_q;
    assign neg       = rem_q ? sa_q : (sa_q ^ sb_q);
    assign signed_op = ~i_op[0];

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        sa_d       = sa_q;
        sb_d       = sb_q;
        q_d        = q_q;
        dvs_d      = dvs_q;
        r_d        = r_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        o_arith_a  = '0;
        o_arith_b  = '0;
        o_arith_op = 2'b00;
`ifdef DIV_RESULT_CACHE_EN
        uns_d      = uns_q;
        a_orig_d   = a_orig_q;
        b_orig_d   = b_orig_q;
        c_valid_d  = c_valid_q;
        c_uns_d    = c_uns_q;
        c_a_d      = c_a_q;
        c_b_d      = c_b_q;
        c_quo_d    = c_quo_q;
        c_rem_d    = c_rem_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    rem_d = i_op[1];
                    sa_d  = signed_op & i_dividend[XLEN-1];
                    sb_d  = signed_op & i_divisor[XLEN-1];
                    q_d   = i_dividend;
                    dvs_d = i_divisor;
                    r_d   = '0;
                    cnt_d = '0;
`ifdef DIV_RESULT_CACHE_EN
                    uns_d    = i_op[0];
                    a_orig_d = i_dividend;
                    b_orig_d = i_divisor;
`endif
                    if (i_divisor == '0) begin
                        result_d = i_op[1] ? i_dividend : '1;
                        state_d  = DONE;
                    end else if (signed_op && (i_dividend == MIN_NEG) && (i_divisor == '1)) begin
                        result_d = i_op[1] ? '0 : MIN_NEG;
                        state_d  = DONE;
                    end else if (cache_hit) begin
`ifdef DIV_RESULT_CACHE_EN
                        result_d = i_op[1] ? c_rem_q : c_quo_q;
`endif
                        state_d  = DONE;
                    end else begin
                        state_d  = NEG_A;
                    end
                end
            end
            NEG_A: begin
                o_arith_b  = q_q;
                o_arith_op = OP_SUB;
                if (sa_q) begin
                    q_d = i_arith_result;
                end
                state_d = NEG_B;
            end
            NEG_B: begin
                o_arith_b  = dvs_q;
                o_arith_op = OP_SUB;
                if (sb_q) begin
                    dvs_d = i_arith_result;
                end
                r_d     = '0;
                cnt_d   = '0;
                state_d = ITER;
            end
            ITER: begin
                o_arith_a  = shifted;
                o_arith_b  = dvs_q;
                o_arith_op = OP_SUB;
                r_d        = ge ? i_arith_result : shifted;
                q_d        = {q_q[XLEN-2:0], ge};
                cnt_d      = cnt_q + CW'(1);
                if (cnt_q == LAST_CNT) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (neg) begin
                    o_arith_b  = sel;
                    o_arith_op = OP_SUB;
                    result_d   = i_arith_result;
                end else begin
                    result_d   = sel;
                end
`ifdef DIV_RESULT_CACHE_EN
                // The cache stores both results already sign-corrected, negated locally
                c_valid_d = 1'b1;
                c_uns_d   = uns_q;
                c_a_d     = a_orig_q;
                c_b_d     = b_orig_q;
                c_quo_d   = (sa_q ^ sb_q) ? ('0 - q_q) : q_q;
                c_rem_d   = sa_q ? ('0 - r_q) : r_q;
`endif
                state_d = DONE;
            end
            DONE: begin
                if (i_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rem_q    <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            q_q      <= '0;
            dvs_q    <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            q_q      <= q_d;
            dvs_q    <= dvs_d;
            r_q      <= r_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

`ifdef DIV_RESULT_CACHE_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            uns_q     <= 1'b0;
            a_orig_q  <= '0;
            b_orig_q  <= '0;
            c_valid_q <= 1'b0;
            c_uns_q   <= 1'b0;
            c_a_q     <= '0;
            c_b_q     <= '0;
            c_quo_q   <= '0;
            c_rem_q   <= '0;
        end else begin
            uns_q     <= uns_d;
            a_orig_q  <= a_orig_d;
            b_orig_q  <= b_orig_d;
            c_valid_q <= c_valid_d;
            c_uns_q   <= c_uns_d;
            c_a_q     <= c_a_d;
            c_b_q     <= c_b_d;
            c_quo_q   <= c_quo_d;
            c_rem_q   <= c_rem_d;
        end
    end
`endif

    assign o_ready  = (state_q == IDLE);
    assign o_valid  = (state_q == DONE);
    assign o_busy   = (state_q != IDLE) && (state_q != DONE);
    assign o_result = result_q;

endmodule
